// File: rtl/bus_qos_arbiter.sv
// Grant scheduler for the 4-master shared bus.
// Masters are granted in round-robin order. An owner that holds the bus
// too long while others are waiting is forced to hand over. A transfer that
// waits too long for m_rdy_n is aborted by a watchdog.
// All grants are registered, and at most one master is granted at a time.
module bus_qos_arbiter #(
  parameter int HOLD_MAX = 255,  // cycles an owner may hold the bus against contenders
  parameter int CNT_W    = 8,    // 2**CNT_W > HOLD_MAX
  parameter int TIMEOUT  = 1024, // cycles an access may wait for m_rdy_n
  parameter int TO_W     = 11    // 2**TO_W > TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_n,
  input  logic       m1_req_n,
  input  logic       m2_req_n,
  input  logic       m3_req_n,
  output logic       m0_grnt_n,
  output logic       m1_grnt_n,
  output logic       m2_grnt_n,
  output logic       m3_grnt_n,
  input  logic       s_as_n,
  input  logic       m_rdy_n,
  output logic [1:0] owner,
  output logic       bus_busy,
  output logic       preempt,
  output logic       timeout_err,
  output logic [1:0] err_master
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    XFER  = 2'd2,
    ABORT = 2'd3
  } state_t;

  state_t           state;
  logic [3:0]       grnt;      // active-high grant vector, one-hot or zero
  logic [1:0]       rr_ptr;    // first master searched in the next pick
  logic [CNT_W-1:0] hold_cnt;  // cycles the current owner has spent in GRANT
  logic [TO_W-1:0]  to_cnt;    // cycles the current access has waited

  logic [3:0]       req;       // active-high request vector
  logic [3:0]       others;    // requests from everyone except the owner
  logic [1:0]       win_any;   // RR winner among all requesters
  logic [1:0]       win_oth;   // RR winner among non-owner requesters

  // Returns the first set bit of r, searching ascending mod 4 from ptr.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    win = ptr;
    // Walk from the farthest offset down so the closest requester wins.
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (r[idx]) win = idx;
    end
    return win;
  endfunction

  assign req     = ~{m3_req_n, m2_req_n, m1_req_n, m0_req_n};
  assign others  = req & ~(4'b0001 << owner);
  assign win_any = rr_pick(req, rr_ptr);
  assign win_oth = rr_pick(others, rr_ptr);

  assign {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n} = ~grnt;
  assign bus_busy = (state == GRANT) || (state == XFER);

  // Arbitration FSM: owns grants, owner, pointers, counters and the event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      grnt        <= '0;
      owner       <= '0;
      rr_ptr      <= '0;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      preempt     <= 1'b0;
      timeout_err <= 1'b0;
      err_master  <= '0;
    end else begin
      // NOTE: state is updated with <= so every branch reads the pre-edge values; where
      // two <= to the same register occur on one path, the later one takes effect.
      preempt     <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (|req) begin
            grnt     <= 4'b0001 << win_any;
            owner    <= win_any;
            rr_ptr   <= win_any + 2'd1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end

        GRANT: begin
          if (hold_cnt != CNT_W'(HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;

          if (!s_as_n) begin
            // Strobe active: either completes this cycle or starts waiting.
            if (m_rdy_n) begin
              state  <= XFER;
              to_cnt <= TO_W'(1);
            end
          end else if (!req[owner]) begin
            // Voluntary release: hand over with no idle gap if anyone waits.
            if (|others) begin
              grnt     <= 4'b0001 << win_oth;
              owner    <= win_oth;
              rr_ptr   <= win_oth + 2'd1;
              hold_cnt <= '0;
            end else begin
              grnt  <= '0;
              state <= IDLE;
            end
          end else if ((hold_cnt == CNT_W'(HOLD_MAX)) && (|others)) begin
            // Owner has held the bus too long against a contender.
            grnt     <= 4'b0001 << win_oth;
            owner    <= win_oth;
            rr_ptr   <= win_oth + 2'd1;
            hold_cnt <= '0;
            preempt  <= 1'b1;
          end
        end

        XFER: begin
          // Grant stays frozen here regardless of the owner's request.
          if (!m_rdy_n) begin
            state  <= GRANT;
            to_cnt <= '0;
          end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
            state       <= ABORT;
            grnt        <= '0;
            timeout_err <= 1'b1;
            err_master  <= owner;
            rr_ptr      <= owner + 2'd1;
            to_cnt      <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ABORT: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          grnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_qos_arbiter.sv
// Self-checking bench for bus_qos_arbiter.
// A transaction-level model (grant flag, wait count, held-cycle count) predicts
// every output each cycle. Directed scenarios pin the model with literal values,
// then randomized traffic runs against the same model.
module tb_bus_qos_arbiter;

  localparam int HOLD_MAX = 4;
  localparam int TIMEOUT  = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_n;
  logic       s_as_n;
  logic       m_rdy_n;

  logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
  logic [1:0] owner;
  logic       bus_busy, preempt, timeout_err;
  logic [1:0] err_master;

  int  total = 0;
  int  bad   = 0;
  bit  chk_on = 1'b0;

  bus_qos_arbiter #(
    .HOLD_MAX (HOLD_MAX),
    .CNT_W    (3),
    .TIMEOUT  (TIMEOUT),
    .TO_W     (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .m0_req_n    (req_n[0]),
    .m1_req_n    (req_n[1]),
    .m2_req_n    (req_n[2]),
    .m3_req_n    (req_n[3]),
    .m0_grnt_n   (m0_grnt_n),
    .m1_grnt_n   (m1_grnt_n),
    .m2_grnt_n   (m2_grnt_n),
    .m3_grnt_n   (m3_grnt_n),
    .s_as_n      (s_as_n),
    .m_rdy_n     (m_rdy_n),
    .owner       (owner),
    .bus_busy    (bus_busy),
    .preempt     (preempt),
    .timeout_err (timeout_err),
    .err_master  (err_master)
  );

  always #5 clk = ~clk;

  logic [3:0]  grnt_n;
  logic [10:0] dut_vec;
  assign grnt_n  = {m3_grnt_n, m2_grnt_n, m1_grnt_n, m0_grnt_n};
  assign dut_vec = {grnt_n, owner, bus_busy, preempt, timeout_err, err_master};

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_granted, m_abort, m_pre, m_terr;
  int m_owner, m_ptr, m_held, m_wait, m_errm;
  int w, held_prev;
  logic [3:0] rq;

  // First requester at or after ptr (mod 4), skipping excl; -1 if none.
  function automatic int pick(input logic [3:0] r, input int ptr, input int excl);
    int idx;
    for (int off = 0; off < 4; off++) begin
      idx = (ptr + off) % 4;
      if (r[idx] && idx != excl) return idx;
    end
    return -1;
  endfunction

  function automatic logic [10:0] model_vec();
    logic [3:0] g;
    for (int i = 0; i < 4; i++) g[i] = !(m_granted && m_owner == i);
    return {g, 2'(m_owner), m_granted, m_pre, m_terr, 2'(m_errm)};
  endfunction

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_granted = 0; m_abort = 0; m_pre = 0; m_terr = 0;
      m_owner = 0; m_ptr = 0; m_held = 0; m_wait = 0; m_errm = 0;
    end else begin
      rq = ~req_n;
      m_pre = 0;
      m_terr = 0;
      if (m_abort) begin
        m_abort = 0;
      end else if (!m_granted) begin
        w = pick(rq, m_ptr, -1);
        if (w >= 0) begin
          m_granted = 1; m_owner = w; m_ptr = (w + 1) % 4; m_held = 0;
        end
      end else if (m_wait > 0) begin
        if (!m_rdy_n) m_wait = 0;
        else if (m_wait == TIMEOUT - 1) begin
          m_granted = 0; m_abort = 1; m_terr = 1; m_errm = m_owner;
          m_ptr = (m_owner + 1) % 4; m_wait = 0;
        end else m_wait++;
      end else begin
        held_prev = m_held;
        m_held++;
        w = pick(rq, m_ptr, m_owner);
        if (!s_as_n) begin
          if (m_rdy_n) m_wait = 1;
        end else if (!rq[m_owner]) begin
          if (w >= 0) begin
            m_owner = w; m_ptr = (w + 1) % 4; m_held = 0;
          end else m_granted = 0;
        end else if (held_prev >= HOLD_MAX && w >= 0) begin
          m_owner = w; m_ptr = (w + 1) % 4; m_held = 0; m_pre = 1;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial forever begin
    @(negedge clk);
    if (chk_on) check("cycle", {5'b0, dut_vec}, {5'b0, model_vec()});
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    reset   = 1'b0;
    req_n   = '1;
    s_as_n  = 1'b1;
    m_rdy_n = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    req_n   = '1;
    s_as_n  = 1'b1;
    m_rdy_n = 1'b1;
    #2 reset = 1'b0;
    #1 chk_on = 1'b1;
    check("rst_grnt", {12'b0, grnt_n}, 16'hF);
    check("rst_owner", {14'b0, owner}, 16'd0);
    check("rst_flags", {13'b0, bus_busy, preempt, timeout_err}, 16'd0);
    check("rst_errm", {14'b0, err_master}, 16'd0);
    @(posedge clk);
    #1 reset = 1'b1;

    // Single request from m2.
    req_n[2] = 1'b0;
    step();
    check("m2_grnt", {12'b0, grnt_n}, 16'b1011);
    check("m2_owner", {14'b0, owner}, 16'd2);
    check("m2_busy", {15'b0, bus_busy}, 16'd1);
    req_n = '1;
    step();
    check("m2_release", {12'b0, grnt_n}, 16'hF);

    // Round robin 0,1,3,0 with back-to-back hand-overs.
    do_reset();
    req_n = 4'b0100;
    step();
    check("rr_0", {12'b0, grnt_n}, 16'b1110);
    req_n = 4'b0101;
    step();
    check("rr_1", {12'b0, grnt_n}, 16'b1101);
    check("rr_1_busy", {15'b0, bus_busy}, 16'd1);
    req_n = 4'b0110;
    step();
    check("rr_3", {12'b0, grnt_n}, 16'b0111);
    req_n = 4'b1110;
    step();
    check("rr_0b", {12'b0, grnt_n}, 16'b1110);
    check("rr_0b_owner", {14'b0, owner}, 16'd0);
    req_n = '1;
    step();

    // Hold limit: m1 holds, m3 contends from the first grant cycle.
    req_n = 4'b1101;
    step();
    check("hold_grant", {12'b0, grnt_n}, 16'b1101);
    req_n = 4'b0101;
    for (int i = 0; i < HOLD_MAX; i++) begin
      step();
      check("hold_keep", {11'b0, grnt_n, preempt}, {11'b0, 4'b1101, 1'b0});
    end
    step();
    check("preempt_grnt", {12'b0, grnt_n}, 16'b0111);
    check("preempt_owner", {14'b0, owner}, 16'd3);
    check("preempt_pulse", {15'b0, preempt}, 16'd1);
    step();
    check("preempt_clear", {15'b0, preempt}, 16'd0);
    req_n = '1;
    step();

    // Slave timeout on m0.
    do_reset();
    req_n = 4'b1110;
    step();
    s_as_n = 1'b0;
    step();
    check("xfer_grnt", {12'b0, grnt_n}, 16'b1110);
    s_as_n = 1'b1;
    for (int i = 0; i < TIMEOUT - 2; i++) begin
      step();
      check("xfer_wait", {11'b0, grnt_n, timeout_err}, {11'b0, 4'b1110, 1'b0});
    end
    step();
    check("to_grnt", {12'b0, grnt_n}, 16'hF);
    check("to_err", {15'b0, timeout_err}, 16'd1);
    check("to_master", {14'b0, err_master}, 16'd0);
    check("to_busy", {15'b0, bus_busy}, 16'd0);
    req_n = '1;
    step();
    check("to_idle", {10'b0, grnt_n, bus_busy, timeout_err}, {10'b0, 4'hF, 2'b00});

    // Ready arrives on the terminal cycle: completion wins.
    req_n = 4'b1110;
    step();
    s_as_n = 1'b0;
    step();
    s_as_n = 1'b1;
    for (int i = 0; i < TIMEOUT - 2; i++) step();
    m_rdy_n = 1'b0;
    step();
    check("late_rdy_err", {15'b0, timeout_err}, 16'd0);
    check("late_rdy_grnt", {12'b0, grnt_n}, 16'b1110);
    m_rdy_n = 1'b1;

    // Asynchronous reset in the middle of a transfer.
    s_as_n = 1'b0;
    step();
    s_as_n = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("async_grnt", {12'b0, grnt_n}, 16'hF);
    check("async_busy", {15'b0, bus_busy}, 16'd0);
    req_n = 4'b0110;
    @(posedge clk);
    #1 reset = 1'b1;
    step();
    check("restart_ptr0", {12'b0, grnt_n}, 16'b1110);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 3) == 0) req_n[i] = ~req_n[i];
      s_as_n  = ($urandom_range(0, 2) != 0);
      m_rdy_n = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end else begin
        step();
      end
    end

    @(negedge clk);
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
